riscv_dmem: RTL and testbench
=============================

RISCV_DMEM -- requirements
Module: riscv_dmem

Interface
REQ-001 SHALL provide parameter ADDR_LENGTH, default 32, byte-address width of req_addr.
REQ-002 SHALL provide parameter NUM_WORDS, default 1024, memory depth in 32-bit words; legal range 1..2^(ADDR_LENGTH-2).
REQ-003 SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port req_valid, input, 1, request present.
REQ-006 SHALL provide port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-007 SHALL provide port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL provide port req_addr, input, ADDR_LENGTH, byte address.
REQ-009 SHALL provide port req_size, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL provide port req_unsigned, input, 1, load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL provide port req_wdata, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL provide port rsp_valid, output, 1, response held in output register.
REQ-013 SHALL provide port rsp_ready, input, 1, consumer takes response.
REQ-014 SHALL provide port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-015 SHALL provide port rsp_err, output, 1, request was misaligned, out of range or illegal size.
REQ-016 SHALL provide port debug, output, 8, byte 0 of word 0, combinational from the array.

Function
REQ-017 SHALL store data as NUM_WORDS x 32-bit words with four byte lanes; word index = req_addr[ADDR_LENGTH-1:2], lane = req_addr[1:0].
REQ-018 SHALL drive req_ready = !rsp_valid || rsp_ready (single-entry response register; full throughput when rsp_ready held high).
REQ-019 SHALL accept a request only on a cycle with req_valid && req_ready; rsp_valid rises on the next edge (latency 1).
REQ-020 SHALL flag an error when req_size==11, size half with addr[0]!=0, size word with addr[1:0]!=0, or word index >= NUM_WORDS.
REQ-021 SHALL, on an accepted error request, leave memory unchanged and return rsp_err=1, rsp_rdata=0.
REQ-022 SHALL, on an accepted legal store, write only the addressed lanes at that edge (byte: 1 lane, half: lanes {1,0} or {3,2}, word: all 4) and return rsp_err=0, rsp_rdata=0.
REQ-023 SHALL, on an accepted legal load, register the addressed bytes shifted to bit 0 and extended per req_unsigned (req_unsigned ignored for word loads).
REQ-024 SHALL return, for a load accepted the cycle after a store to the same bytes, the newly stored data.
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
REQ-026 SHALL clear rsp_valid on the edge where rsp_valid && rsp_ready and no new request is accepted; when both occur, the new response replaces the old one with rsp_valid staying 1.
REQ-027 SHALL ignore req_* inputs on cycles when the request is not accepted.

Reset
REQ-028 SHALL, while rst_n==0, force rsp_valid=0, rsp_err=0, rsp_rdata=0 asynchronously; req_ready then reads 1.
REQ-029 SHALL NOT reset the memory array; contents persist across reset.
REQ-030 SHALL discard any pending response when reset asserts mid-operation; a store accepted on the same edge that reset asserts is not guaranteed.

Verification
REQ-031 SHALL cover: store word 0xDEADBEEF at 0x10, load word 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after acceptance.
REQ-032 SHALL cover: after REQ-031, signed byte load 0x13 -> 0xFFFFFFDE; unsigned half load 0x12 -> 0x0000DEAD; signed half load 0x10 -> 0xFFFFBEEF.
REQ-033 SHALL cover: store byte 0x5A at 0x11, load word 0x10 -> 0xDEAD5AEF (other lanes untouched); debug equals byte at address 0 throughout.
REQ-034 SHALL cover: word load at 0x12, half store at 0x01, size 11, and load at byte address 4*NUM_WORDS -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-035 SHALL cover: rsp_ready held 0 for 3 cycles with back-to-back requests -> req_ready=0, response stable, second request accepted only on the cycle rsp_ready rises; then rsp_ready=1 continuous -> one response per cycle.
REQ-036 SHALL cover: rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately; after release, earlier stored words still readable unchanged.

Source files
------------

// File: rtl/riscv_dmem.sv
// riscv_dmem: single-cycle data memory for the load/store unit.
// Byte/half/word loads and stores behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend loads when 1
//   req_wdata         right-aligned store data
//   rsp_valid/ready   response handshake (one-entry register)
//   rsp_rdata         extended load data, 0 for stores/errors
//   rsp_err           misaligned, out of range or illegal size
//   debug             byte 0 of word 0
module riscv_dmem #(
  parameter int ADDR_LENGTH = 32,
  parameter int NUM_WORDS   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [7:0]             debug
);

  localparam int IW = ADDR_LENGTH - 2;
  localparam int MW =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW:0] LIMIT =
    (IW+1)'(NUM_WORDS);

  logic [31:0]   mem [NUM_WORDS];

  logic [IW-1:0] widx;
  logic [MW-1:0] idx;
  logic [1:0]    lane;
  logic          oob;
  logic          mis;
  logic          err;
  logic          acc;
  logic          wr;
  logic          sx;
  logic          sz_b;
  logic          sz_h;
  logic          sz_w;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rword;
  logic [31:0]   sh;
  logic [31:0]   ld;

  assign widx = req_addr[ADDR_LENGTH-1:2];
  assign idx  = widx[MW-1:0];
  assign lane = req_addr[1:0];
  assign oob  = {1'b0, widx} >= LIMIT;

  assign sz_b = req_size == 2'b00;
  assign sz_h = req_size == 2'b01;
  assign sz_w = req_size == 2'b10;
  assign sx   = !req_unsigned;

  // Out-of-range reads are masked so no bogus index reaches the array.
  assign rword = oob ? '0 : mem[idx];
  assign sh    = rword >> {lane, 3'b000};

  // Store data is replicated across lanes; the byte enable picks the lane.
  always_comb begin
    mis = 1'b0;
    be  = '0;
    wd  = '0;
    ld  = '0;
    unique case (1'b1)
      sz_b: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
        ld = {{24{sx & sh[7]}}, sh[7:0]};
      end
      sz_h: begin
        mis = lane[0];
        be  = lane[1] ? 4'b1100 : 4'b0011;
        wd  = {2{req_wdata[15:0]}};
        ld  = {{16{sx & sh[15]}}, sh[15:0]};
      end
      sz_w: begin
        mis = |lane;
        be  = 4'b1111;
        wd  = req_wdata;
        ld  = sh;
      end
      default: mis = 1'b1;
    endcase
  end

  assign err = mis | oob;
  assign acc = req_valid & req_ready;
  assign wr  = acc & req_we & ~err;

  assign req_ready = !rsp_valid || rsp_ready;

  // The array keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (err | req_we) ? '0 : ld;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign debug = mem[0][7:0];

endmodule

// File: tb/tb_riscv_dmem.sv
// tb_riscv_dmem: vector table, handshake sequences and random
// traffic checked against a byte-array memory model.
module tb_riscv_dmem;

  localparam int NW = 64;
  localparam int NB = 4 * NW;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  debug;

  riscv_dmem #(
    .ADDR_LENGTH(32),
    .NUM_WORDS  (NW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .debug       (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] mbytes [NB];

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic        e;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, little-endian.
  function automatic void model(input logic we,
                                input logic [31:0] a,
                                input logic [1:0] sz,
                                input logic u,
                                input logic [31:0] wd,
                                output logic e,
                                output logic [31:0] r);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0])
        || (sz == 2'd2 && a[1:0] != 2'd0)
        || (a >= 32'(NB));
    r = '0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < n; i++)
        mbytes[a + 32'(i)] = wd[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(mbytes[a + 32'(i)]) << (8 * i));
    if (!u && sz == 2'd0 && v[7])
      v = v | 32'hFFFF_FF00;
    if (!u && sz == 2'd1 && v[15])
      v = v | 32'hFFFF_0000;
    r = v;
  endfunction

  task automatic drive(input logic we,
                       input logic [31:0] a,
                       input logic [1:0] sz,
                       input logic u,
                       input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    req_wdata    = wd;
  endtask

  // One accepted transaction with rsp_ready high.
  task automatic xact(input string nm,
                      input logic we,
                      input logic [31:0] a,
                      input logic [1:0] sz,
                      input logic u,
                      input logic [31:0] wd,
                      input logic use_tab,
                      input logic te,
                      input logic [31:0] tr);
    logic me;
    logic [31:0] mr;
    drive(we, a, sz, u, wd);
    rsp_ready = 1'b1;
    @(posedge clk);
    model(we, a, sz, u, wd, me, mr);
    if (use_tab) begin
      me = te;
      mr = tr;
    end
    #1;
    req_valid = 1'b0;
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_err"}, 32'(rsp_err), 32'(me));
    chk({nm, "_rdata"}, rsp_rdata, mr);
    chk({nm, "_debug"}, 32'(debug), 32'(mbytes[0]));
  endtask

  logic        rv, rwe, ru, rr;
  logic [31:0] ra, rwd;
  logic [1:0]  rsz;
  logic        ev, ee, me;
  logic [31:0] er, mr, exp_a;

  initial begin
    rst_n        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    rsp_ready    = 1'b0;

    vecs[0]  = '{1, 32'h10, 2, 0, 32'hDEADBEEF, 0, 32'h0};
    vecs[1]  = '{0, 32'h10, 2, 0, 32'h0, 0, 32'hDEADBEEF};
    vecs[2]  = '{0, 32'h13, 0, 0, 32'h0, 0, 32'hFFFFFFDE};
    vecs[3]  = '{0, 32'h12, 1, 1, 32'h0, 0, 32'h0000DEAD};
    vecs[4]  = '{0, 32'h10, 1, 0, 32'h0, 0, 32'hFFFFBEEF};
    vecs[5]  = '{1, 32'h11, 0, 0, 32'hFFFFFF5A, 0, 32'h0};
    vecs[6]  = '{0, 32'h10, 2, 0, 32'h0, 0, 32'hDEAD5AEF};
    vecs[7]  = '{0, 32'h12, 2, 0, 32'h0, 1, 32'h0};
    vecs[8]  = '{1, 32'h01, 1, 0, 32'h1234, 1, 32'h0};
    vecs[9]  = '{0, 32'h10, 3, 0, 32'h0, 1, 32'h0};
    vecs[10] = '{0, 32'h100, 2, 0, 32'h0, 1, 32'h0};
    vecs[11] = '{1, 32'h100, 2, 0, 32'h11111111, 1, 32'h0};
    vecs[12] = '{0, 32'h10, 2, 0, 32'h0, 0, 32'hDEAD5AEF};
    vecs[13] = '{1, 32'hFC, 2, 0, 32'hCAFEF00D, 0, 32'h0};
    vecs[14] = '{0, 32'hFC, 2, 0, 32'h0, 0, 32'hCAFEF00D};
    vecs[15] = '{0, 32'hFF, 0, 1, 32'h0, 0, 32'h000000CA};
    vecs[16] = '{1, 32'h02, 1, 0, 32'hABCD8001, 0, 32'h0};
    vecs[17] = '{0, 32'h02, 1, 0, 32'h0, 0, 32'hFFFF8001};
    vecs[18] = '{0, 32'h10, 2, 1, 32'h0, 0, 32'hDEAD5AEF};
    vecs[19] = '{1, 32'h00, 0, 0, 32'h7E, 0, 32'h0};
    vecs[20] = '{0, 32'h00, 0, 0, 32'h0, 0, 32'h0000007E};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known contents everywhere
    for (int w = 0; w < NW; w++)
      xact("init", 1, 32'(4 * w), 2, 0,
           (32'(w) * 32'h01030507) ^ 32'hA5A55A5A,
           0, 0, 0);

    for (int i = 0; i < 21; i++)
      xact($sformatf("vec%0d", i), vecs[i].we,
           vecs[i].a, vecs[i].sz, vecs[i].u,
           vecs[i].wd, 1, vecs[i].e, vecs[i].r);

    // Backpressure: response held, second request stalls
    drive(0, 32'h10, 2, 0, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    model(0, 32'h10, 2, 0, 0, me, exp_a);
    #1;
    rsp_ready = 1'b0;
    drive(0, 32'hFC, 2, 0, 0);
    #1;
    chk("bp_ready0", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold", rsp_rdata, exp_a);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready1", 32'(req_ready), 32'd1);
    @(posedge clk);
    model(0, 32'hFC, 2, 0, 0, me, mr);
    #1;
    chk("bp_second", rsp_rdata, mr);
    for (int j = 0; j < 4; j++) begin
      drive(0, 32'(32 + 4 * j), 2, 0, 0);
      @(posedge clk);
      model(0, 32'(32 + 4 * j), 2, 0, 0, me, mr);
      #1;
      chk("stream_valid", 32'(rsp_valid), 32'd1);
      chk("stream_rdata", rsp_rdata, mr);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    // Reset while a response is pending
    drive(0, 32'h10, 2, 0, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    xact("post_rst_10", 0, 32'h10, 2, 0, 0, 0, 0, 0);
    xact("post_rst_fc", 0, 32'hFC, 2, 0, 0, 0, 0, 0);
    xact("post_rst_00", 0, 32'h00, 2, 0, 0, 0, 0, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rnd_start", 32'(rsp_valid), 32'd0);

    // Random traffic with random backpressure
    ev = 1'b0;
    ee = 1'b0;
    er = '0;
    for (int k = 0; k < 500; k++) begin
      rv  = $urandom_range(0, 3) != 0;
      rwe = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 15) == 0) ? $urandom
            : 32'($urandom_range(0, NB + 7));
      rsz = 2'($urandom_range(0, 3));
      ru  = 1'($urandom_range(0, 1));
      rwd = $urandom;
      rr  = $urandom_range(0, 3) != 0;
      drive(rwe, ra, rsz, ru, rwd);
      req_valid = rv;
      rsp_ready = rr;
      #1;
      chk("rnd_ready", 32'(req_ready), 32'(!ev || rr));
      @(posedge clk);
      if (rv && (!ev || rr)) begin
        model(rwe, ra, rsz, ru, rwd, ee, er);
        ev = 1'b1;
      end else if (rr) begin
        ev = 1'b0;
      end
      #1;
      chk("rnd_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rnd_err", 32'(rsp_err), 32'(ee));
        chk("rnd_rdata", rsp_rdata, er);
      end
      chk("rnd_debug", 32'(debug), 32'(mbytes[0]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
